// File: rtl/mul_err_sweep_ctrl_if.sv
// Bundle between the error-sweep controller, its host (start/stall/done/metrics)
// and the combinational multiplier under evaluation (op_a/op_b/approx_prod).
interface mul_err_sweep_ctrl_if #(
    parameter int W = 8
) ();
    logic               start;
    logic               stall;
    logic [W-1:0]       op_a;
    logic [W-1:0]       op_b;
    logic [2*W-1:0]     approx_prod;
    logic               busy;
    logic               done;
    logic [2*W:0]       err_cnt;
    logic [4*W-1:0]     err_sum;
    logic [6*W-1:0]     err_sq_sum;
    logic [2*W-1:0]     err_max;
    logic [W-1:0]       max_a;
    logic [W-1:0]       max_b;

    // Host / multiplier side: drives start, stall and the product.
    modport master (
        output start,
        output stall,
        output approx_prod,
        input  op_a,
        input  op_b,
        input  busy,
        input  done,
        input  err_cnt,
        input  err_sum,
        input  err_sq_sum,
        input  err_max,
        input  max_a,
        input  max_b
    );

    // Controller side.
    modport slave (
        input  start,
        input  stall,
        input  approx_prod,
        output op_a,
        output op_b,
        output busy,
        output done,
        output err_cnt,
        output err_sum,
        output err_sq_sum,
        output err_max,
        output max_a,
        output max_b
    );
endinterface

// File: rtl/mul_err_sweep_ctrl.sv
// Exhaustive operand sweep for an approximate multiplier: presents every (a,b),
// compares against the exact product two stages later and accumulates error metrics.
module mul_err_sweep_ctrl #(
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mul_err_sweep_ctrl_if.slave  bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       state_reg;
    logic [2*W-1:0]   idx_reg;          // {op_a, op_b}, op_b is the fast digit
    logic             drain_cnt_reg;

    logic             s1_valid_reg;
    logic [W-1:0]     s1_a_reg;
    logic [W-1:0]     s1_b_reg;
    logic [2*W-1:0]   s1_exact_reg;
    logic [2*W-1:0]   s1_approx_reg;

    logic [2*W:0]     err_cnt_reg;
    logic [4*W-1:0]   err_sum_reg;
    logic [6*W-1:0]   err_sq_sum_reg;
    logic [2*W-1:0]   err_max_reg;
    logic [W-1:0]     max_a_reg;
    logic [W-1:0]     max_b_reg;

    logic [W-1:0]     op_a_w;
    logic [W-1:0]     op_b_w;
    logic [2*W-1:0]   pp_w [W];
    logic [2*W-1:0]   exact_w;
    logic [2*W-1:0]   err_w;
    logic [4*W-1:0]   err_sq_w;
    logic             err_nz_w;

    logic             idle_like_w;
    logic             active_w;
    logic             advance_w;
    logic             accept_w;
    logic             acc_en_w;
    logic             last_idx_w;

    assign op_a_w = idx_reg[2*W-1:W];
    assign op_b_w = idx_reg[W-1:0];

    // Reference product as a shift-add array of partial products.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_pp
            assign pp_w[gi] = {{W{1'b0}}, (op_b_w & {W{op_a_w[gi]}})} << gi;
        end
    endgenerate

    always_comb begin
        exact_w = '0;
        for (int i = 0; i < W; i++) begin
            exact_w = exact_w + pp_w[i];
        end
    end

    assign err_w    = (s1_exact_reg >= s1_approx_reg) ? (s1_exact_reg - s1_approx_reg)
                                                      : (s1_approx_reg - s1_exact_reg);
    assign err_sq_w = {{(2*W){1'b0}}, err_w} * {{(2*W){1'b0}}, err_w};
    assign err_nz_w = |err_w;

    assign idle_like_w = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
    assign active_w    = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    assign advance_w   = active_w && !bus.stall;
    assign accept_w    = idle_like_w && bus.start;
    assign acc_en_w    = advance_w && s1_valid_reg;
    assign last_idx_w  = &idx_reg;

    // Sequencer: operand counter and state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            drain_cnt_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state_reg     <= ST_RUN;
                        idx_reg       <= '0;
                        drain_cnt_reg <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!bus.stall) begin
                        if (last_idx_w) begin
                            state_reg     <= ST_DRAIN;
                            drain_cnt_reg <= 1'b0;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!bus.stall) begin
                        if (drain_cnt_reg) begin
                            state_reg <= ST_DONE;
                        end else begin
                            drain_cnt_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Stage 1: capture operands, exact and approximate products.
    always_ff @(posedge clk) begin
        if (rst || accept_w) begin
            s1_valid_reg  <= 1'b0;
            s1_a_reg      <= '0;
            s1_b_reg      <= '0;
            s1_exact_reg  <= '0;
            s1_approx_reg <= '0;
        end else if (advance_w) begin
            s1_valid_reg  <= (state_reg == ST_RUN);
            s1_a_reg      <= op_a_w;
            s1_b_reg      <= op_b_w;
            s1_exact_reg  <= exact_w;
            s1_approx_reg <= bus.approx_prod;
        end
    end

    // Stage 2: accumulate; strict compare keeps the first pair on ties.
    always_ff @(posedge clk) begin
        if (rst || accept_w) begin
            err_cnt_reg    <= '0;
            err_sum_reg    <= '0;
            err_sq_sum_reg <= '0;
            err_max_reg    <= '0;
            max_a_reg      <= '0;
            max_b_reg      <= '0;
        end else if (acc_en_w) begin
            err_cnt_reg    <= err_cnt_reg + {{(2*W){1'b0}}, err_nz_w};
            err_sum_reg    <= err_sum_reg + {{(2*W){1'b0}}, err_w};
            err_sq_sum_reg <= err_sq_sum_reg + {{(2*W){1'b0}}, err_sq_w};
            if (err_w > err_max_reg) begin
                err_max_reg <= err_w;
                max_a_reg   <= s1_a_reg;
                max_b_reg   <= s1_b_reg;
            end
        end
    end

    assign bus.op_a       = op_a_w;
    assign bus.op_b       = op_b_w;
    assign bus.busy       = active_w;
    assign bus.done       = (state_reg == ST_DONE);
    assign bus.err_cnt    = err_cnt_reg;
    assign bus.err_sum    = err_sum_reg;
    assign bus.err_sq_sum = err_sq_sum_reg;
    assign bus.err_max    = err_max_reg;
    assign bus.max_a      = max_a_reg;
    assign bus.max_b      = max_b_reg;
endmodule

// File: tb/tb_mul_err_sweep_ctrl.sv
// Bench for mul_err_sweep_ctrl at W=4: behavioural multiplier models, expected
// metrics queued at start and compared when done rises.
module tb_mul_err_sweep_ctrl;
    localparam int W = 4;
    localparam int N = 1 << (2 * W);

    typedef struct packed {
        logic [2*W:0]   cnt;
        logic [4*W-1:0] sum;
        logic [6*W-1:0] sq;
        logic [2*W-1:0] mx;
        logic [W-1:0]   ma;
        logic [W-1:0]   mb;
    } met_t;

    logic clk = 1'b0;
    logic rst;
    int   model_sel;
    int   n_cmp;
    int   n_bad;
    met_t exp_q[$];

    always #5 clk = ~clk;

    mul_err_sweep_ctrl_if #(.W(W)) bus ();
    mul_err_sweep_ctrl #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [2*W-1:0] ref_model(input int m, input logic [W-1:0] a,
                                                  input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (m)
            0:       return p;
            1:       return '0;
            2:       return p ^ (2*W)'(1);
            default: return (a > b) ? (p ^ (2*W)'(4)) : p;
        endcase
    endfunction

    always_comb bus.approx_prod = ref_model(model_sel, bus.op_a, bus.op_b);

    function automatic met_t compute_exp(input int m);
        longint cnt, sum, sq, mx, ma, mb, e, ap, d;
        met_t r;
        cnt = 0; sum = 0; sq = 0; mx = 0; ma = 0; mb = 0;
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                e  = longint'(a) * longint'(b);
                ap = longint'(ref_model(m, W'(a), W'(b)));
                d  = (e >= ap) ? (e - ap) : (ap - e);
                if (d != 0) cnt++;
                sum += d;
                sq  += d * d;
                if (d > mx) begin
                    mx = d; ma = a; mb = b;
                end
            end
        end
        r.cnt = cnt[2*W:0];
        r.sum = sum[4*W-1:0];
        r.sq  = sq[6*W-1:0];
        r.mx  = mx[2*W-1:0];
        r.ma  = ma[W-1:0];
        r.mb  = mb[W-1:0];
        return r;
    endfunction

    function automatic met_t cur_metrics();
        met_t r;
        r.cnt = bus.err_cnt;
        r.sum = bus.err_sum;
        r.sq  = bus.err_sq_sum;
        r.mx  = bus.err_max;
        r.ma  = bus.max_a;
        r.mb  = bus.max_b;
        return r;
    endfunction

    // Drives one sweep; also monitors the operand sequence and the clear on start.
    task automatic run_sweep(input int model, input int stall_pct, input int restart_at,
                             output int cycles, output int stalls, output int busy_cycles);
        int k;
        int budget;
        logic [2*W-1:0] exp_op;
        met_t zero_m;
        zero_m = '0;
        budget = 4 * N + 100;
        model_sel = model;
        exp_q.push_back(compute_exp(model));
        @(negedge clk);
        bus.start = 1'b1;
        bus.stall = (stall_pct > 0) ? 1'b1 : 1'b0;
        @(posedge clk);
        cycles = 1; stalls = 0; busy_cycles = 0; k = 0;
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++;
        if (cur_metrics() !== zero_m || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_on_start: metrics=%h busy=%b done=%b, required 0/1/0",
                     cur_metrics(), bus.busy, bus.done);
        end
        while (bus.done !== 1'b1 && cycles < budget) begin
            bus.start = (cycles == restart_at) ? 1'b1 : 1'b0;
            bus.stall = (stall_pct > 0 && $urandom_range(99) < stall_pct) ? 1'b1 : 1'b0;
            if (bus.busy === 1'b1) begin
                busy_cycles++;
                if (bus.stall) stalls++;
                else begin
                    exp_op = (k < N) ? (2*W)'(k) : (2*W)'(N - 1);
                    n_cmp++;
                    if ({bus.op_a, bus.op_b} !== exp_op) begin
                        n_bad++;
                        $display("FAIL op_seq: got %h required %h", {bus.op_a, bus.op_b}, exp_op);
                    end
                    if (k < N) k++;
                end
            end
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
        if (bus.done !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: done=%b after %0d cycles, required 1", bus.done, cycles);
        end
        $display("sweep model=%0d cycles=%0d stalls=%0d busy_cycles=%0d", model, cycles,
                 stalls, busy_cycles);
    endtask

    task automatic test_reset();
        met_t zero_m;
        zero_m = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (cur_metrics() !== zero_m || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.op_a !== '0 || bus.op_b !== '0) begin
            n_bad++;
            $display("FAIL reset: metrics=%h busy=%b done=%b op=%h, required all 0",
                     cur_metrics(), bus.busy, bus.done, {bus.op_a, bus.op_b});
        end
        $display("reset checked");
    endtask

    task automatic test_model(input string name, input int model, input int stall_pct,
                              input int restart_at);
        int cyc, st, bc;
        met_t e;
        run_sweep(model, stall_pct, restart_at, cyc, st, bc);
        n_cmp++;
        if (cyc !== N + 3 + st) begin
            n_bad++;
            $display("FAIL %s_latency: done at cycle %0d, required %0d", name, cyc, N + 3 + st);
        end
        n_cmp++;
        if (bc !== N + 2 + st) begin
            n_bad++;
            $display("FAIL %s_busy_len: %0d cycles, required %0d", name, bc, N + 2 + st);
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s_queue: got empty, required one entry", name);
        end else begin
            e = exp_q.pop_front();
            if (cur_metrics() !== e) begin
                n_bad++;
                $display("FAIL %s_metrics: got cnt=%0d sum=%0d sq=%0d max=%0d a=%0d b=%0d required cnt=%0d sum=%0d sq=%0d max=%0d a=%0d b=%0d",
                         name, bus.err_cnt, bus.err_sum, bus.err_sq_sum, bus.err_max,
                         bus.max_a, bus.max_b, e.cnt, e.sum, e.sq, e.mx, e.ma, e.mb);
            end
        end
        // Metrics must hold while idling in DONE.
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b1 || cur_metrics() !== e) begin
            n_bad++;
            $display("FAIL %s_hold: done=%b metrics=%h required 1/%h", name, bus.done,
                     cur_metrics(), e);
        end
    endtask

    task automatic test_exact();
        test_model("exact", 0, 0, -1);
    endtask

    task automatic test_zero();
        met_t e;
        e = compute_exp(1);
        // Closed-form sanity of the zero model at W=4.
        n_cmp++;
        if (e.sum !== (4*W)'(14400) || e.mx !== (2*W)'(225) || e.ma !== W'(15) || e.mb !== W'(15)) begin
            n_bad++;
            $display("FAIL zero_model_ref: sum=%0d max=%0d a=%0d b=%0d required 14400/225/15/15",
                     e.sum, e.mx, e.ma, e.mb);
        end
        test_model("zero", 1, 0, -1);
    endtask

    task automatic test_xor_tie();
        test_model("xor1", 2, 0, -1);
        n_cmp++;
        if (bus.err_cnt !== (2*W+1)'(256) || bus.err_max !== (2*W)'(1) ||
            bus.max_a !== '0 || bus.max_b !== '0) begin
            n_bad++;
            $display("FAIL xor1_tie: cnt=%0d max=%0d a=%0d b=%0d required 256/1/0/0",
                     bus.err_cnt, bus.err_max, bus.max_a, bus.max_b);
        end
    endtask

    task automatic test_stall();
        test_model("stall", 1, 30, -1);
    endtask

    task automatic test_start_while_busy();
        test_model("restart_busy", 1, 0, 100);
    endtask

    task automatic test_reset_mid_sweep();
        met_t zero_m;
        zero_m = '0;
        model_sel = 1;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (120) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (cur_metrics() !== zero_m || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.op_a !== '0 || bus.op_b !== '0) begin
            n_bad++;
            $display("FAIL mid_reset: metrics=%h busy=%b done=%b op=%h, required all 0",
                     cur_metrics(), bus.busy, bus.done, {bus.op_a, bus.op_b});
        end
        $display("mid-sweep reset checked");
        test_model("after_reset", 2, 0, -1);
    endtask

    task automatic test_back_to_back();
        test_model("b2b_first", 1, 0, -1);
        test_model("b2b_second", 3, 0, -1);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        model_sel = 0;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        rst = 1'b1;
        test_reset();
        test_exact();
        test_zero();
        test_xor_tie();
        test_stall();
        test_start_while_busy();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
